// File: rtl/rib_bus_arbiter.sv
// Round-robin arbiter for the shared RIB slave bus: one grant per transaction,
// released on ack, requester withdrawal or watchdog expiry.
module rib_bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ID_W        = 2,
    parameter int CORE_ID     = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic                   ack_i,
    output logic [NUM_MASTERS-1:0] grant_o,
    output logic [ID_W-1:0]        grant_id_o,
    output logic                   busy_o,
    output logic                   hold_flag_o,
    output logic                   timeout_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;
    localparam logic [ID_W-1:0] ID_LAST = ID_W'(NUM_MASTERS - 1);

    state_t                 state_r, state_n;
    logic [ID_W-1:0]        ptr_r, ptr_n;
    logic [15:0]            cnt_r, cnt_n;
    logic [NUM_MASTERS-1:0] grant_r, grant_n;
    logic [ID_W-1:0]        id_r, id_n;
    logic                   tmo_r, tmo_n;

    logic                   any_req_s;
    logic                   wdog_s;
    logic                   release_s;
    logic [ID_W-1:0]        rel_ptr_s;
    logic [ID_W-1:0]        win_idle_s;
    logic [ID_W-1:0]        win_rel_s;

    // First requester found scanning start, start+1, ... modulo NUM_MASTERS.
    function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                                input logic [ID_W-1:0] start);
        logic [ID_W-1:0] win;
        logic            found;
        int              idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx = int'(start) + i;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            if (!found && req[idx]) begin
                win   = ID_W'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [ID_W-1:0] id);
        logic [NUM_MASTERS-1:0] oh;
        oh     = '0;
        oh[id] = 1'b1;
        return oh;
    endfunction

    assign any_req_s  = |req_i;
    assign rel_ptr_s  = (id_r == ID_LAST) ? '0 : id_r + ID_W'(1);
    assign win_idle_s = rr_pick(req_i, ptr_r);
    assign win_rel_s  = rr_pick(req_i, rel_ptr_s);
    // Ack has priority over abort, abort over watchdog: only a pure expiry pulses timeout_o.
    assign wdog_s     = ~ack_i & req_i[id_r] & (cnt_r == CNT_LAST);
    assign release_s  = ack_i | ~req_i[id_r] | (cnt_r == CNT_LAST);

    // Next-state, grant and watchdog logic.
    always_comb begin
        state_n = state_r;
        ptr_n   = ptr_r;
        cnt_n   = cnt_r;
        grant_n = grant_r;
        id_n    = id_r;
        tmo_n   = 1'b0;
        case (state_r)
            IDLE: begin
                if (any_req_s) begin
                    state_n = BUSY;
                    id_n    = win_idle_s;
                    grant_n = onehot(win_idle_s);
                    cnt_n   = 16'd0;
                end else begin
                    grant_n = '0;
                    id_n    = '0;
                end
            end
            BUSY: begin
                if (release_s) begin
                    ptr_n = rel_ptr_s;
                    tmo_n = wdog_s;
                    cnt_n = 16'd0;
                    if (any_req_s) begin
                        id_n    = win_rel_s;
                        grant_n = onehot(win_rel_s);
                    end else begin
                        state_n = IDLE;
                        id_n    = '0;
                        grant_n = '0;
                    end
                end else if (cnt_r != CNT_MAX) begin
                    cnt_n = cnt_r + 16'd1;
                end else begin
                    cnt_n = cnt_r;
                end
            end
            default: begin
                state_n = IDLE;
                ptr_n   = '0;
                cnt_n   = 16'd0;
                grant_n = '0;
                id_n    = '0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            ptr_r   <= '0;
            cnt_r   <= 16'd0;
            grant_r <= '0;
            id_r    <= '0;
            tmo_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            ptr_r   <= ptr_n;
            cnt_r   <= cnt_n;
            grant_r <= grant_n;
            id_r    <= id_n;
            tmo_r   <= tmo_n;
        end
    end

    assign grant_o     = grant_r;
    assign grant_id_o  = id_r;
    assign busy_o      = (state_r == BUSY);
    assign timeout_o   = tmo_r;
    // Combinational so the pipeline stalls in the very cycle the core requests.
    assign hold_flag_o = req_i[CORE_ID] & ~grant_r[CORE_ID];

endmodule

// File: tb/tb_rib_bus_arbiter.sv
// Scoreboard bench for rib_bus_arbiter: the driver queues per-cycle expected
// outputs, a negedge monitor pops and compares them.
module tb_rib_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       ack;
    logic [3:0] grant;
    logic [1:0] gid;
    logic       busy;
    logic       hold;
    logic       tmo;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [3:0] grant;
        logic [1:0] id;
        logic       id_care;
        logic       busy;
        logic       tmo;
        logic       hold;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    rib_bus_arbiter #(
        .NUM_MASTERS(4),
        .ID_W       (2),
        .CORE_ID    (0),
        .TIMEOUT    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_i      (req),
        .ack_i      (ack),
        .grant_o    (grant),
        .grant_id_o (gid),
        .busy_o     (busy),
        .hold_flag_o(hold),
        .timeout_o  (tmo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if (mon_e.cyc != cyc || grant !== mon_e.grant || busy !== mon_e.busy ||
                tmo !== mon_e.tmo || hold !== mon_e.hold ||
                (mon_e.id_care && gid !== mon_e.id)) begin
                errors++;
                $display("FAIL %s cyc=%0d got grant=%b id=%0d busy=%b tmo=%b hold=%b want grant=%b id=%0d busy=%b tmo=%b hold=%b",
                         mon_e.name, cyc, grant, gid, busy, tmo, hold,
                         mon_e.grant, mon_e.id, mon_e.busy, mon_e.tmo, mon_e.hold);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_push(input string nm, input logic [3:0] g, input logic [1:0] id,
                            input logic idc, input logic b, input logic t, input logic h);
        exp_t x;
        x.cyc     = cyc;
        x.grant   = g;
        x.id      = id;
        x.id_care = idc;
        x.busy    = b;
        x.tmo     = t;
        x.hold    = h;
        x.name    = nm;
        sb.push_back(x);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] oh;
        int         m;
        rst = 1'b1;
        req = 4'b0000;
        ack = 1'b0;

        // Reset values, and hold_flag following req[0] while in reset.
        tick(); chk_push("reset", 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); req = 4'b0001; chk_push("reset_hold", 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick(); req = 4'b0000; rst = 1'b0;

        // Single request, ack with request withdrawn.
        tick(); req = 4'b0001; chk_push("t1_req", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); chk_push("t1_grant", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (grant !== 4'b0001 || gid !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL t1_direct grant=%b id=%0d busy=%b", grant, gid, busy);
        end
        tick(); chk_push("t1_held", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); ack = 1'b1; req = 4'b0000; chk_push("t1_ack", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); ack = 1'b0; chk_push("t1_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Round robin 0,1,2,3,0 with back-to-back grants.
        do_reset();
        tick(); req = 4'b1111; chk_push("t2_req", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            m  = k % 4;
            oh = 4'b0001 << m;
            tick(); ack = 1'b0; chk_push("t2_grant", oh, 2'(m), 1'b1, 1'b1, 1'b0, m != 0);
            if (k < 4) begin
                tick(); ack = 1'b1; chk_push("t2_ackcyc", oh, 2'(m), 1'b1, 1'b1, 1'b0, m != 0);
            end
        end
        tick(); req = 4'b0000; ack = 1'b1; chk_push("t2_drain", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); ack = 1'b0; chk_push("t2_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // No preemption of master 2; next grant wraps to master 0.
        tick(); req = 4'b0100; chk_push("t3_req", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); req = 4'b0111; chk_push("t3_grant", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int j = 0; j < 3; j++) begin
            tick();
            if (j == 2) ack = 1'b1;
            chk_push("t3_nopreempt", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        end
        tick(); req = 4'b0000; chk_push("t3_wrap", 4'b0001, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (grant !== 4'b0001 || gid !== 2'd0) begin
            errors++;
            $display("FAIL t3_direct grant=%b id=%0d", grant, gid);
        end
        tick(); ack = 1'b0; chk_push("t3_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Watchdog: 8 cycles of grant, one-cycle timeout pulse, re-grant of sole requester.
        tick(); req = 4'b0010; chk_push("t4_req", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 8; j++) begin
            tick(); chk_push("t4_grant", 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        tick(); chk_push("t4_timeout", 4'b0010, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (tmo !== 1'b1 || grant !== 4'b0010) begin
            errors++;
            $display("FAIL t4_direct tmo=%b grant=%b", tmo, grant);
        end
        tick(); req = 4'b1000; chk_push("t4_pulse_end", 4'b0010, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Aborts: master 1 withdraws (master 3 wins), then master 3 withdraws.
        tick(); req = 4'b0000; chk_push("t5_grant3", 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); req = 4'b0100; chk_push("t5_abort_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Ack coinciding with the last watchdog cycle is an ordinary ack.
        for (int j = 0; j < 8; j++) begin
            tick();
            if (j == 7) ack = 1'b1;
            chk_push("t5_count", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        tick(); ack = 1'b0; chk_push("t5_ack_wd", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); chk_push("t5_after", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset between clock edges.
        tick(); #2 rst = 1'b1; chk_push("t6_async", 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL t6_direct grant=%b busy=%b", grant, busy);
        end
        tick(); chk_push("t6_held", 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); rst = 1'b0; chk_push("t6_release", 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); req = 4'b0000; ack = 1'b1; chk_push("t6_grant", 4'b0100, 2'd2, 1'b1, 1'b1, 1'b0, 1'b0);

        // Ack while idle is ignored.
        tick(); chk_push("ack_idle", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); ack = 1'b0; chk_push("ack_idle2", 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) tick();
        while (sb.size() != 0) begin
            mon_e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s never compared, queued for cyc=%0d now cyc=%0d", mon_e.name, mon_e.cyc, cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
